// File: rtl/matrix_display_scheduler_if.sv
// Requester/flash/scan-side signal bundle for the matrix display scheduler.
// master = requesters and scanner side, slave = the scheduler itself.
interface matrix_display_scheduler_if;
    logic        board_req;
    logic [34:0] board_data;
    logic        hit_req;
    logic [34:0] hit_data;
    logic        flash_start;
    logic [34:0] flash_data;
    logic        board_gnt;
    logic        hit_gnt;
    logic        flash_busy;
    logic        frame_tick;
    logic [6:0]  col1;
    logic [6:0]  col2;
    logic [6:0]  col3;
    logic [6:0]  col4;
    logic [6:0]  col5;

    modport master (
        output board_req, board_data, hit_req, hit_data, flash_start, flash_data,
        input  board_gnt, hit_gnt, flash_busy, frame_tick, col1, col2, col3, col4, col5
    );

    modport slave (
        input  board_req, board_data, hit_req, hit_data, flash_start, flash_data,
        output board_gnt, hit_gnt, flash_busy, frame_tick, col1, col2, col3, col4, col5
    );
endinterface

// File: rtl/matrix_display_scheduler.sv
// Arbitrates the 5x7 matrix between board preview and hit map, overlays a blink flash,
// and only changes content at frame boundaries of the 5-column scan.
module matrix_display_scheduler #(
    parameter int DWELL_FRAMES     = 1000,
    parameter int FLASH_ON_FRAMES  = 200,
    parameter int FLASH_OFF_FRAMES = 200,
    parameter int FLASH_BLINKS     = 3
) (
    input  logic clk,
    input  logic reset_n,
    matrix_display_scheduler_if.slave bus
);
    localparam int DW   = $clog2(DWELL_FRAMES) + 1;
    localparam int FMAX = (FLASH_ON_FRAMES > FLASH_OFF_FRAMES) ? FLASH_ON_FRAMES : FLASH_OFF_FRAMES;
    localparam int FW   = $clog2(FMAX) + 1;
    localparam int BW   = $clog2(FLASH_BLINKS) + 1;

    typedef enum logic [1:0] {IDLE, BOARD, HITS, FLASH} state_t;

    state_t          state_q, state_d, ret_q, ret_d, arb_cur, arb_nxt;
    logic [2:0]      col_idx_q;
    logic            tick, capture, do_arb;
    logic [34:0]     cols_q, cols_d, pat_q, pat_d;
    logic [DW-1:0]   dwell_q, dwell_d, arb_dwell;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic            last_hit_q, last_hit_d;
    logic            busy_q, busy_d;
    logic            phase_on_q, phase_on_d;

    function automatic state_t arbitrate(state_t cur, logic [DW-1:0] dwell,
                                         logic b, logic h, logic last_hit);
        state_t nxt;
        nxt = cur;
        case (cur)
            IDLE: begin
                if (b && h)  nxt = last_hit ? BOARD : HITS;
                else if (b)  nxt = BOARD;
                else if (h)  nxt = HITS;
            end
            BOARD: begin
                if (!b)                                           nxt = h ? HITS : IDLE;
                else if (h && int'(dwell) >= DWELL_FRAMES - 1)    nxt = HITS;
            end
            HITS: begin
                if (!h)                                           nxt = b ? BOARD : IDLE;
                else if (b && int'(dwell) >= DWELL_FRAMES - 1)    nxt = BOARD;
            end
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    always_comb begin
        tick       = (col_idx_q == 3'd4);
        capture    = bus.flash_start && !busy_q;
        state_d    = state_q;
        ret_d      = ret_q;
        cols_d     = cols_q;
        pat_d      = pat_q;
        dwell_d    = dwell_q;
        fcnt_d     = fcnt_q;
        blink_d    = blink_q;
        last_hit_d = last_hit_q;
        busy_d     = busy_q;
        phase_on_d = phase_on_q;
        do_arb     = 1'b0;
        arb_cur    = state_q;
        arb_dwell  = dwell_q;
        arb_nxt    = state_q;

        if (capture) begin
            pat_d  = bus.flash_data;
            busy_d = 1'b1;
        end

        if (tick) begin
            if (state_q == FLASH) begin
                if (phase_on_q) begin
                    if (int'(fcnt_q) >= FLASH_ON_FRAMES - 1) begin
                        phase_on_d = 1'b0;
                        fcnt_d     = '0;
                        cols_d     = '0;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end else if (int'(fcnt_q) < FLASH_OFF_FRAMES - 1) begin
                    fcnt_d = fcnt_q + 1'b1;
                end else if (int'(blink_q) < FLASH_BLINKS - 1) begin
                    blink_d    = blink_q + 1'b1;
                    phase_on_d = 1'b1;
                    fcnt_d     = '0;
                    cols_d     = pat_q;
                end else begin
                    // Flash done: resume arbitration as if from the interrupted holder, fresh dwell.
                    busy_d    = 1'b0;
                    do_arb    = 1'b1;
                    arb_cur   = ret_q;
                    arb_dwell = '0;
                end
            end else if (busy_q || capture) begin
                state_d    = FLASH;
                ret_d      = state_q;
                cols_d     = busy_q ? pat_q : bus.flash_data;
                fcnt_d     = '0;
                blink_d    = '0;
                phase_on_d = 1'b1;
                dwell_d    = '0;
            end else begin
                do_arb = 1'b1;
            end
        end

        if (do_arb) begin
            arb_nxt = arbitrate(arb_cur, arb_dwell, bus.board_req, bus.hit_req, last_hit_q);
            state_d = arb_nxt;
            if (arb_nxt == state_q && arb_nxt != IDLE)
                dwell_d = (int'(dwell_q) < DWELL_FRAMES - 1) ? dwell_q + 1'b1 : dwell_q;
            else
                dwell_d = '0;
            case (arb_nxt)
                BOARD: begin
                    cols_d     = bus.board_data;
                    last_hit_d = 1'b0;
                end
                HITS: begin
                    cols_d     = bus.hit_data;
                    last_hit_d = 1'b1;
                end
                default: cols_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ret_q      <= IDLE;
            col_idx_q  <= '0;
            cols_q     <= '0;
            pat_q      <= '0;
            dwell_q    <= '0;
            fcnt_q     <= '0;
            blink_q    <= '0;
            last_hit_q <= 1'b1;
            busy_q     <= 1'b0;
            phase_on_q <= 1'b0;
        end else begin
            col_idx_q  <= tick ? 3'd0 : col_idx_q + 3'd1;
            state_q    <= state_d;
            ret_q      <= ret_d;
            cols_q     <= cols_d;
            pat_q      <= pat_d;
            dwell_q    <= dwell_d;
            fcnt_q     <= fcnt_d;
            blink_q    <= blink_d;
            last_hit_q <= last_hit_d;
            busy_q     <= busy_d;
            phase_on_q <= phase_on_d;
        end
    end

    assign bus.board_gnt  = (state_q == BOARD);
    assign bus.hit_gnt    = (state_q == HITS);
    assign bus.flash_busy = busy_q;
    assign bus.frame_tick = tick;
    assign bus.col1       = cols_q[6:0];
    assign bus.col2       = cols_q[13:7];
    assign bus.col3       = cols_q[20:14];
    assign bus.col4       = cols_q[27:21];
    assign bus.col5       = cols_q[34:28];
endmodule

// File: tb/tb_matrix_display_scheduler.sv
// Frame-level scoreboard bench for matrix_display_scheduler with small dwell/flash parameters.
module tb_matrix_display_scheduler;
    localparam int FS_NONE = 0;
    localparam int FS_TICK = 1;
    localparam int FS_MID  = 2;

    localparam logic [34:0] Z    = 35'h0;
    localparam logic [34:0] B1   = 35'h1;
    localparam logic [34:0] B80  = 35'h80;
    localparam logic [34:0] HD   = 35'h7_F000_0000;
    localparam logic [34:0] ONES = 35'h7_FFFF_FFFF;
    localparam logic [34:0] P    = 35'h2_AAAA_AAAA;

    typedef struct {
        logic        bg;
        logic        hg;
        logic        busy;
        logic [34:0] cols;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   frame_no = 1;
    logic sb_on = 1'b0;
    exp_t q[$];

    matrix_display_scheduler_if bus();

    matrix_display_scheduler #(
        .DWELL_FRAMES(2),
        .FLASH_ON_FRAMES(1),
        .FLASH_OFF_FRAMES(1),
        .FLASH_BLINKS(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_tick && n < 20);
        if (!bus.frame_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no frame_tick expected one within 20 cycles");
        end
    endtask

    // One frame of stimulus; the expectation covers the frame loaded at this tick edge.
    task automatic fr(input logic b, input logic [34:0] bd, input logic h, input logic [34:0] hd,
                      input int fs, input logic [34:0] fd,
                      input logic ebg, input logic ehg, input logic ebusy, input logic [34:0] ec);
        exp_t e;
        int   n;
        bus.board_req  = b;
        bus.board_data = bd;
        bus.hit_req    = h;
        bus.hit_data   = hd;
        bus.flash_data = fd;
        if (fs == FS_TICK) bus.flash_start = 1'b1;
        e.bg = ebg; e.hg = ehg; e.busy = ebusy; e.cols = ec; e.id = frame_no;
        q.push_back(e);
        frame_no++;
        @(negedge clk);
        bus.flash_start = 1'b0;
        if (fs == FS_MID) begin
            bus.flash_start = 1'b1;
            @(negedge clk);
            bus.flash_start = 1'b0;
        end
        wait_tick(n);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnts"}, 64'({bus.board_gnt, bus.hit_gnt}), 64'd0);
        check({tag, "_busy"}, 64'(bus.flash_busy), 64'd0);
        check({tag, "_cols"}, 64'({bus.col5, bus.col4, bus.col3, bus.col2, bus.col1}), 64'd0);
        check({tag, "_tick"}, 64'(bus.frame_tick), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_on && bus.frame_tick) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got a frame with no expectation queued");
                end else begin
                    e = q.pop_front();
                    check($sformatf("frame%0d{bg,hg,busy,cols}", e.id),
                          64'({bus.board_gnt, bus.hit_gnt, bus.flash_busy,
                               bus.col5, bus.col4, bus.col3, bus.col2, bus.col1}),
                          64'({e.bg, e.hg, e.busy, e.cols}));
                end
                check("gnt_exclusive", 64'(bus.board_gnt & bus.hit_gnt), 64'd0);
            end
        end
    end

    initial begin : stimulus
        int n;
        reset_n         = 1'b0;
        bus.board_req   = 1'b0;
        bus.board_data  = Z;
        bus.hit_req     = 1'b0;
        bus.hit_data    = Z;
        bus.flash_start = 1'b0;
        bus.flash_data  = Z;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_idle_outputs("reset");
        wait_tick(n);
        check("first_tick_cycles", 64'(n), 64'd4);
        wait_tick(n);
        check("tick_period", 64'(n), 64'd5);
        #1;
        sb_on = 1'b1;

        fr(0, Z,   0, Z,  FS_NONE, Z,    0, 0, 0, Z);
        fr(1, B1,  0, Z,  FS_NONE, Z,    1, 0, 0, B1);
        fr(1, B80, 0, Z,  FS_NONE, Z,    1, 0, 0, B80);
        fr(1, B80, 1, HD, FS_NONE, Z,    0, 1, 0, HD);
        fr(1, B80, 1, HD, FS_NONE, Z,    0, 1, 0, HD);
        fr(1, B80, 1, HD, FS_NONE, Z,    1, 0, 0, B80);
        fr(1, B80, 1, HD, FS_NONE, Z,    1, 0, 0, B80);
        fr(1, B80, 1, HD, FS_NONE, Z,    0, 1, 0, HD);
        fr(1, B80, 1, HD, FS_MID,  ONES, 0, 1, 1, HD);
        fr(1, B80, 1, HD, FS_NONE, Z,    0, 0, 1, ONES);
        fr(1, B80, 1, HD, FS_MID,  B1,   0, 0, 1, Z);
        fr(1, B80, 1, HD, FS_NONE, Z,    0, 0, 1, ONES);
        fr(1, B80, 1, HD, FS_NONE, Z,    0, 0, 1, Z);
        fr(1, B80, 1, HD, FS_NONE, Z,    0, 1, 0, HD);
        fr(0, B80, 1, HD, FS_NONE, Z,    0, 1, 0, HD);
        fr(1, B80, 1, HD, FS_TICK, ONES, 0, 0, 1, ONES);
        fr(1, B80, 0, HD, FS_NONE, Z,    0, 0, 1, Z);
        fr(1, B80, 0, HD, FS_NONE, Z,    0, 0, 1, ONES);
        fr(1, B80, 0, HD, FS_NONE, Z,    0, 0, 1, Z);
        fr(1, B80, 0, HD, FS_NONE, Z,    1, 0, 0, B80);
        fr(0, B80, 0, HD, FS_NONE, Z,    0, 0, 0, Z);
        fr(1, B80, 0, HD, FS_MID,  P,    1, 0, 1, B80);
        fr(1, B80, 1, HD, FS_NONE, Z,    0, 0, 1, P);

        sb_on = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.board_req = 1'b0;
        bus.hit_req   = 1'b0;
        check_idle_outputs("midflash_reset");
        wait_tick(n);
        check("post_reset_first_tick", 64'(n), 64'd4);
        #1;
        sb_on = 1'b1;

        fr(1, B1, 1, HD, FS_NONE, Z, 1, 0, 0, B1);
        fr(1, B1, 1, HD, FS_NONE, Z, 1, 0, 0, B1);
        fr(1, B1, 1, HD, FS_NONE, Z, 0, 1, 0, HD);

        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
